// File: rtl/cache_pkg.sv
// Shared types and default widths for the cache refill controller.
package cache_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    FILL    = 3'd3,
    WR_REQ  = 3'd4
  } refill_state_t;

endpackage

// File: rtl/cache_refill_controller_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != {WIDTH{1'b1}})) begin
      cnt_o <= cnt_o + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/cache_refill_controller.sv
// Read-miss refill and write-through/no-allocate store controller behind the cache.
// Optional hit/miss performance counters are enabled by defining CACHE_PERF_CNT_EN.
module cache_refill_controller
  import cache_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_re_i,
  input  logic                  cpu_we_i,
  input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
  input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
  output logic [DATA_WIDTH-1:0] cpu_rdata_o,
  output logic                  stall_o,
  input  logic                  cache_hit_i,
  input  logic [DATA_WIDTH-1:0] cache_rdata_i,
  output logic                  fill_we_o,
  output logic [ADDR_WIDTH-1:0] fill_addr_o,
  output logic [DATA_WIDTH-1:0] fill_data_o,
  output logic                  cache_ovw_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [31:0]           hit_cnt_o,
  output logic [31:0]           miss_cnt_o
`endif
);

  refill_state_t         state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] fill_q;
  logic                  hit_q;
  logic [ADDR_WIDTH-1:0] addr_word;
  logic                  addr_lsb_unused;

  // Byte offset is dropped at the latch so every memory/fill address is word aligned.
  assign addr_word       = {cpu_addr_i[ADDR_WIDTH-1:2], 2'b00};
  assign addr_lsb_unused = ^cpu_addr_i[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      fill_q  <= '0;
      hit_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        if (cpu_we_i) begin
          addr_q  <= addr_word;
          wdata_q <= cpu_wdata_i;
          hit_q   <= cache_hit_i;
        end else if (cpu_re_i && !cache_hit_i) begin
          addr_q <= addr_word;
        end
      end
      if ((state == RD_WAIT) && mem_rvalid_i) begin
        fill_q <= mem_rdata_i;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    stall_o     = 1'b0;
    cpu_rdata_o = '0;
    fill_we_o   = 1'b0;
    cache_ovw_o = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_we_i) begin
          stall_o   = 1'b1;
          state_nxt = WR_REQ;
        end else if (cpu_re_i) begin
          if (cache_hit_i) begin
            cpu_rdata_o = cache_rdata_i;
          end else begin
            stall_o   = 1'b1;
            state_nxt = RD_REQ;
          end
        end
      end
      RD_REQ: begin
        mem_req_o = 1'b1;
        stall_o   = 1'b1;
        if (mem_gnt_i) state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        stall_o = 1'b1;
        if (mem_rvalid_i) state_nxt = FILL;
      end
      FILL: begin
        fill_we_o   = 1'b1;
        cpu_rdata_o = fill_q;
        state_nxt   = IDLE;
      end
      WR_REQ: begin
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
        if (mem_gnt_i) begin
          cache_ovw_o = hit_q;
          state_nxt   = IDLE;
        end else begin
          stall_o = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address and write data come straight from the latches so they stay stable until gnt.
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign fill_addr_o = addr_q;
  assign fill_data_o = fill_q;

`ifdef CACHE_PERF_CNT_EN
  logic hit_inc;
  logic miss_inc;

  assign hit_inc  = (state == IDLE) && cpu_re_i && cache_hit_i && !cpu_we_i;
  assign miss_inc = (state == IDLE) && cpu_re_i && !cache_hit_i && !cpu_we_i;

  sat_counter #(.WIDTH(32)) u_hit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (hit_inc),
    .cnt_o (hit_cnt_o)
  );

  sat_counter #(.WIDTH(32)) u_miss_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (miss_inc),
    .cnt_o (miss_cnt_o)
  );
`endif

endmodule

// File: tb/tb_cache_refill_controller.sv
// Directed testbench for cache_refill_controller and its saturating counter.
module tb_cache_refill_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_re = 1'b0;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        stall;
  logic        cache_hit = 1'b0;
  logic [31:0] cache_rdata = '0;
  logic        fill_we;
  logic [31:0] fill_addr;
  logic [31:0] fill_data;
  logic        cache_ovw;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
`ifdef CACHE_PERF_CNT_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif
  logic        sat_inc = 1'b0;
  logic [1:0]  sat_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cache_refill_controller #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cpu_re_i      (cpu_re),
    .cpu_we_i      (cpu_we),
    .cpu_addr_i    (cpu_addr),
    .cpu_wdata_i   (cpu_wdata),
    .cpu_rdata_o   (cpu_rdata),
    .stall_o       (stall),
    .cache_hit_i   (cache_hit),
    .cache_rdata_i (cache_rdata),
    .fill_we_o     (fill_we),
    .fill_addr_o   (fill_addr),
    .fill_data_o   (fill_data),
    .cache_ovw_o   (cache_ovw),
    .mem_req_o     (mem_req),
    .mem_we_o      (mem_we),
    .mem_addr_o    (mem_addr),
    .mem_wdata_o   (mem_wdata),
    .mem_gnt_i     (mem_gnt),
    .mem_rvalid_i  (mem_rvalid),
    .mem_rdata_i   (mem_rdata)
`ifdef CACHE_PERF_CNT_EN
    ,
    .hit_cnt_o     (hit_cnt),
    .miss_cnt_o    (miss_cnt)
`endif
  );

  sat_counter #(.WIDTH(2)) u_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (sat_inc),
    .cnt_o (sat_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] ored;
    step();
    step();
    ored = {31'b0, stall} | {31'b0, mem_req} | {31'b0, mem_we} | {31'b0, fill_we} |
           {31'b0, cache_ovw} | cpu_rdata | mem_addr | mem_wdata | fill_addr | fill_data;
    checks++;
    if (ored !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=%h", ored, 32'h0);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_read_hit();
    cpu_re = 1'b1; cpu_addr = 32'h10; cache_hit = 1'b1; cache_rdata = 32'hA5A5;
    #1;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL hit_stall got=%b exp=0", stall); end
    checks++;
    if (cpu_rdata !== 32'hA5A5) begin failures++; $display("FAIL hit_rdata got=%h exp=%h", cpu_rdata, 32'hA5A5); end
    checks++;
    if (mem_req !== 1'b0) begin failures++; $display("FAIL hit_memreq got=%b exp=0", mem_req); end
    step();
    cpu_re = 1'b0; cache_hit = 1'b0; cache_rdata = '0;
    step();
  endtask

  task automatic test_read_miss();
    int stalls = 0;
    int fills = 0;
    int reqs = 0;
    cpu_re = 1'b1; cpu_addr = 32'h24; cache_hit = 1'b0;
    for (int c = 0; c < 10; c++) begin
      mem_gnt    = (c == 3);
      mem_rvalid = (c == 6);
      mem_rdata  = (c == 6) ? 32'hDEAD : 32'h0;
      if (c >= 2) cpu_addr = 32'h100;
      if (c >= 8) cpu_re = 1'b0;
      #1;
      if (stall) stalls++;
      if (mem_req) begin
        reqs++;
        checks++;
        if (mem_addr !== 32'h24 || mem_we !== 1'b0) begin
          failures++;
          $display("FAIL miss_req c=%0d addr=%h we=%b exp addr=%h we=0", c, mem_addr, mem_we, 32'h24);
        end
      end
      if (fill_we) begin
        fills++;
        checks++;
        if (c != 7 || fill_data !== 32'hDEAD || fill_addr !== 32'h24 || cpu_rdata !== 32'hDEAD || stall !== 1'b0) begin
          failures++;
          $display("FAIL miss_fill c=%0d data=%h addr=%h rdata=%h stall=%b exp c=7 data=dead addr=24 rdata=dead stall=0",
                   c, fill_data, fill_addr, cpu_rdata, stall);
        end
      end
      step();
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    checks++;
    if (stalls != 7) begin failures++; $display("FAIL miss_stall_cycles got=%0d exp=7", stalls); end
    checks++;
    if (fills != 1) begin failures++; $display("FAIL miss_fill_pulses got=%0d exp=1", fills); end
    checks++;
    if (reqs != 3) begin failures++; $display("FAIL miss_req_cycles got=%0d exp=3", reqs); end
  endtask

  task automatic test_store(input logic hit);
    cpu_we = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'h1234; cache_hit = hit;
    #1;
    checks++;
    if (stall !== 1'b1) begin failures++; $display("FAIL store_idle_stall hit=%b got=%b exp=1", hit, stall); end
    step();
    mem_gnt = 1'b1; cache_hit = ~hit;
    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h40 || mem_wdata !== 32'h1234) begin
      failures++;
      $display("FAIL store_mem hit=%b req=%b we=%b addr=%h wdata=%h exp 1 1 40 1234", hit, mem_req, mem_we, mem_addr, mem_wdata);
    end
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL store_gnt_stall hit=%b got=%b exp=0", hit, stall); end
    checks++;
    if (cache_ovw !== hit) begin failures++; $display("FAIL store_ovw hit=%b got=%b exp=%b", hit, cache_ovw, hit); end
    step();
    cpu_we = 1'b0; mem_gnt = 1'b0; cache_hit = 1'b0;
    #1;
    checks++;
    if (cache_ovw !== 1'b0 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL store_done ovw=%b req=%b exp 0 0", cache_ovw, mem_req);
    end
    step();
  endtask

  task automatic test_reset_mid();
    cpu_re = 1'b1; cpu_addr = 32'h50; cache_hit = 1'b0;
    step();
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || stall !== 1'b1) begin
      failures++;
      $display("FAIL rdwait_entry req=%b stall=%b exp 0 1", mem_req, stall);
    end
    rst_n = 1'b0; cpu_re = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0 || mem_req !== 1'b0 || fill_we !== 1'b0 || mem_addr !== 32'h0 || cpu_rdata !== 32'h0) begin
      failures++;
      $display("FAIL midreset_outputs stall=%b req=%b fill=%b addr=%h rdata=%h exp all 0",
               stall, mem_req, fill_we, mem_addr, cpu_rdata);
    end
    step();
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'hBEEF;
    step();
    mem_rvalid = 1'b0; mem_rdata = '0;
    #1;
    checks++;
    if (fill_we !== 1'b0 || fill_data !== 32'h0 || stall !== 1'b0) begin
      failures++;
      $display("FAIL stale_rvalid fill=%b data=%h stall=%b exp 0 0 0", fill_we, fill_data, stall);
    end
    cpu_re = 1'b1; cpu_addr = 32'h14; cache_hit = 1'b1; cache_rdata = 32'h77;
    #1;
    checks++;
    if (stall !== 1'b0 || cpu_rdata !== 32'h77) begin
      failures++;
      $display("FAIL post_reset_hit stall=%b rdata=%h exp 0 77", stall, cpu_rdata);
    end
    step();
    cpu_re = 1'b0; cache_hit = 1'b0; cache_rdata = '0;
    step();
  endtask

  task automatic test_store_and_load();
    cpu_re = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h8; cpu_wdata = 32'h55;
    cache_hit = 1'b1; cache_rdata = 32'h99;
    #1;
    checks++;
    if (stall !== 1'b1 || cpu_rdata !== 32'h0) begin
      failures++;
      $display("FAIL dual_idle stall=%b rdata=%h exp 1 0", stall, cpu_rdata);
    end
    step();
    mem_gnt = 1'b1;
    #1;
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 32'h8 || mem_wdata !== 32'h55 || cache_ovw !== 1'b1 || stall !== 1'b0) begin
      failures++;
      $display("FAIL dual_store we=%b addr=%h wdata=%h ovw=%b stall=%b exp 1 8 55 1 0",
               mem_we, mem_addr, mem_wdata, cache_ovw, stall);
    end
    step();
    cpu_re = 1'b0; cpu_we = 1'b0; mem_gnt = 1'b0; cache_hit = 1'b0; cache_rdata = '0;
    #1;
    checks++;
    if (fill_we !== 1'b0 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL dual_after fill=%b req=%b exp 0 0", fill_we, mem_req);
    end
    mem_rvalid = 1'b1; mem_rdata = 32'hF00D;
    #1;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL spurious_stall got=%b exp=0", stall); end
    step();
    mem_rvalid = 1'b0; mem_rdata = '0;
    #1;
    checks++;
    if (fill_we !== 1'b0 || fill_data !== 32'h0 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL spurious_rvalid fill=%b data=%h req=%b exp 0 0 0", fill_we, fill_data, mem_req);
    end
    step();
  endtask

`ifdef CACHE_PERF_CNT_EN
  task automatic test_perf();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    cpu_re = 1'b1; cache_hit = 1'b1; cpu_addr = 32'h20;
    for (int i = 0; i < 3; i++) step();
    cache_hit = 1'b0;
    for (int m = 0; m < 2; m++) begin
      cpu_addr = 32'h60 + m * 4;
      step();
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0; mem_rvalid = 1'b1;
      step();
      mem_rvalid = 1'b0;
      step();
    end
    cpu_re = 1'b0;
    #1;
    checks++;
    if (hit_cnt !== 32'd3) begin failures++; $display("FAIL perf_hits got=%0d exp=3", hit_cnt); end
    checks++;
    if (miss_cnt !== 32'd2) begin failures++; $display("FAIL perf_misses got=%0d exp=2", miss_cnt); end
    step();
  endtask
`endif

  task automatic test_saturation();
    logic [1:0] exp;
    #1;
    checks++;
    if (sat_cnt !== 2'd0) begin failures++; $display("FAIL sat_start got=%0d exp=0", sat_cnt); end
    sat_inc = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      exp = (i >= 3) ? 2'd3 : 2'(i);
      checks++;
      if (sat_cnt !== exp) begin failures++; $display("FAIL sat_count i=%0d got=%0d exp=%0d", i, sat_cnt, exp); end
    end
    sat_inc = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_read_hit();
    test_read_miss();
    test_store(1'b1);
    test_store(1'b0);
    test_reset_mid();
    test_store_and_load();
`ifdef CACHE_PERF_CNT_EN
    test_perf();
`endif
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
